aes_inv_sbox_seq: RTL and testbench
===================================

AES_INV_SBOX_SEQ -- requirements
Module: aes_inv_sbox_seq

Interface
REQ-001 The block SHALL have parameter INV_ONLY, default 0: when 1, skip the inverse affine transform and output the pure GF(2^8) inverse.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1 bit: input byte a is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an input.
REQ-006 The block SHALL have port a, input, 8 bits: S-box output byte to be inverted.
REQ-007 The block SHALL have port out_valid, output, 1 bit: result d is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts d.
REQ-009 The block SHALL have port d, output, 8 bits: inverse S-box result.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 The block SHALL compute d = InvSbox(a) per FIPS-197: first the inverse affine transform, then the GF(2^8) inverse.
- Inverse affine: b_i = a_{(i+2)%8} ^ a_{(i+5)%8} ^ a_{(i+7)%8} ^ c_i, with c = 0x05.
- GF(2^8) inverse: x^254 mod x^8+x^4+x^3+x+1 (0x11B), with 0 mapped to 0.
REQ-012 When INV_ONLY=1, the block SHALL skip the affine step and use b = a.
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 in_ready SHALL equal (state==IDLE) and out_valid SHALL equal (state==DONE), both decoded from registered state.
REQ-015 Accept: on a rising edge with state==IDLE and in_valid=1, the block SHALL:
- load t <= b and r <= 0x01;
- clear the 3-bit step counter cnt <= 0;
- go to CALC.
REQ-016 In CALC, each edge SHALL update t <= t*t and r <= r*(t*t) (GF products, combinational), and increment cnt.
REQ-017 On the CALC edge where cnt==6 (7th step), the block SHALL go to DONE and register d <= r*(t*t).
REQ-018 Latency SHALL be exactly 7 cycles from the accept edge to out_valid=1; no early or late assertion.
REQ-019 In DONE, d and out_valid SHALL hold stable until an edge with out_ready=1, which SHALL return the FSM to IDLE.
REQ-020 There SHALL be no accept in the same cycle as output release: the next input is accepted at the earliest 1 cycle after the output handshake.
REQ-021 The block SHALL sample a only at the accept edge; changes to a during CALC or DONE SHALL NOT affect d.
REQ-022 While state is not IDLE, in_valid SHALL be ignored and no input SHALL be queued.
REQ-023 a = 0x00 with INV_ONLY=1 SHALL yield d = 0x00 (zero maps to zero naturally via x^254).

Reset
REQ-024 While rst_n=0 at an edge, the block SHALL force:
- state = IDLE, in_ready = 1, out_valid = 0, busy = 0;
- d = 0x00, t = 0x00, r = 0x01, cnt = 0.
REQ-025 A reset during CALC or DONE SHALL abort the operation: the pending result is discarded and no out_valid pulse occurs.
REQ-026 On the first edge after rst_n returns high, a new accept SHALL be possible if in_valid=1.

Verification
REQ-027 Known values, back-to-back with out_ready=1: a=0x63->d=0x00; a=0x7C->d=0x01; a=0x00->d=0x52; a=0xED->d=0x53; a=0x16->d=0xFF; each with out_valid exactly 7 cycles after accept.
REQ-028 Exhaustive: all 256 inputs, in ascending then descending order; Sbox(d)==a for every result, against a forward S-box golden model.
REQ-029 Backpressure: out_ready held 0 for 10 cycles in DONE, with a and in_valid toggling -> d, out_valid stable, in_ready=0, no extra accept.
REQ-030 Reset mid-CALC: rst_n=0 at step 3 for 1 cycle -> out_valid never asserts for that input, d=0x00, in_ready=1 on the next cycle.
REQ-031 INV_ONLY=1: a=0x02->d=0x8D; a=0x53->d=0xCA; a=0x00->d=0x00.
REQ-032 in_valid applied on the negedge-changing input stream: the sampled value at the accept posedge SHALL determine d.

Source files
------------

// File: rtl/aes_inv_sbox_seq.sv
// Sequential AES inverse S-box: inverse affine transform followed by a GF(2^8)
// inversion computed as x^254 through seven square-and-multiply steps.
module aes_inv_sbox_seq #(
    parameter int INV_ONLY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [7:0] AFFINE_C  = 8'h05;
    localparam logic [2:0] LAST_STEP = 3'd6;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] t;
    logic [7:0] r;
    logic [2:0] cnt;
    logic [7:0] affine;
    logic [7:0] b;
    logic [7:0] t_sq;
    logic [7:0] r_nxt;

    // GF(2^8) product modulo x^8+x^4+x^3+x+1 by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // b_i = a_(i+2) ^ a_(i+5) ^ a_(i+7) ^ c_i, written as right-rotations of a.
    always_comb begin
        affine = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ AFFINE_C;
        b      = (INV_ONLY != 0) ? a : affine;
    end

    always_comb begin
        t_sq  = gf_mul(t, t);
        r_nxt = gf_mul(r, t_sq);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (cnt == LAST_STEP) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // After step k, t = b^(2^k) and r = b^(2+4+...+2^k); step 7 yields b^254.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t   <= '0;
            r   <= 8'h01;
            cnt <= '0;
            d   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        t   <= b;
                        r   <= 8'h01;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    t   <= t_sq;
                    r   <= r_nxt;
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_STEP) d <= r_nxt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// Bench for aes_inv_sbox_seq: two instances (full inverse S-box and INV_ONLY)
// driven in lockstep, checked against a brute-force GF/forward S-box model.
module tb_aes_inv_sbox_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic       in_ready0, out_valid0, busy0;
    logic       in_ready1, out_valid1, busy1;
    logic [7:0] d0, d1;

    always #5 clk = ~clk;

    aes_inv_sbox_seq #(.INV_ONLY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a),
        .out_valid(out_valid0), .out_ready(out_ready), .d(d0), .busy(busy0)
    );

    aes_inv_sbox_seq #(.INV_ONLY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .a(a),
        .out_valid(out_valid1), .out_ready(out_ready), .d(d1), .busy(busy1)
    );

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] ginv_t[256];
    logic [7:0] sb[256];
    logic [7:0] inv_sb[256];

    // Schoolbook polynomial product, then reduction by 0x11B.
    function automatic logic [7:0] tb_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (15'(x) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] bb;
        logic [7:0] yy;
        ginv_t[0] = 8'h00;
        for (int x = 1; x < 256; x++) begin
            for (int y = 1; y < 256; y++) begin
                yy = 8'(y);
                if (tb_mul(8'(x), yy) == 8'h01) ginv_t[x] = yy;
            end
        end
        for (int x = 0; x < 256; x++) begin
            bb = ginv_t[x];
            sb[x] = bb ^ {bb[6:0], bb[7]} ^ {bb[5:0], bb[7:6]} ^ {bb[4:0], bb[7:5]}
                       ^ {bb[3:0], bb[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_sb[sb[x]] = 8'(x);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk({tag, "/d0"}, 16'(d0), 16'(e));
        end else chk({tag, "/q0_empty"}, 16'h1, 16'h0);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk({tag, "/d1"}, 16'(d1), 16'(e));
        end else chk({tag, "/q1_empty"}, 16'h1, 16'h0);
    endtask

    // Called and returns at a negedge, with out_ready=1 for a back-to-back flow.
    task automatic run_one(input logic [7:0] val, input logic [7:0] e0, input logic [7:0] e1,
                           input string tag);
        int w;
        int lat;
        w = 0;
        while (!(in_ready0 && in_ready1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "/ready"}, 16'(in_ready0 & in_ready1), 16'h1);
        a        = val;
        in_valid = 1'b1;
        q0.push_back(e0);
        q1.push_back(e1);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid0 && lat < 20) begin
            a        = 8'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "/lat"}, 16'(lat), 16'd7);
        chk({tag, "/ov1"}, 16'(out_valid1), 16'h1);
        chk({tag, "/rdy_done"}, 16'(in_ready0), 16'h0);
        chk({tag, "/fwd"}, 16'(sb[d0]), 16'(val));
        pop_chk(tag);
        @(negedge clk);
        chk({tag, "/released"}, 16'({in_ready0, out_valid0}), 16'b10);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        build_tables();

        repeat (3) @(negedge clk);
        chk("rst/ready",  16'({in_ready0, in_ready1}), 16'b11);
        chk("rst/ovalid", 16'({out_valid0, out_valid1}), 16'b00);
        chk("rst/busy",   16'({busy0, busy1}), 16'b00);
        chk("rst/d",      16'({d0, d1}), 16'h0000);
        rst_n = 1'b1;

        // Known values, back-to-back.
        run_one(8'h63, 8'h00, ginv_t[8'h63], "kv63");
        run_one(8'h7C, 8'h01, ginv_t[8'h7C], "kv7C");
        run_one(8'h00, 8'h52, 8'h00, "kv00");
        run_one(8'hED, 8'h53, ginv_t[8'hED], "kvED");
        run_one(8'h16, 8'hFF, ginv_t[8'h16], "kv16");
        run_one(8'h02, inv_sb[8'h02], 8'h8D, "io02");
        run_one(8'h53, inv_sb[8'h53], 8'hCA, "io53");

        // Exhaustive sweep, ascending then descending.
        for (int i = 0; i < 256; i++) run_one(8'(i), inv_sb[i], ginv_t[i], "up");
        for (int i = 255; i >= 0; i--) run_one(8'(i), inv_sb[i], ginv_t[i], "dn");

        // Backpressure: result held for 10 cycles with noisy inputs.
        out_ready = 1'b0;
        a         = 8'hED;
        in_valid  = 1'b1;
        q0.push_back(8'h53);
        q1.push_back(ginv_t[8'hED]);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp/lat", 16'(lat), 16'd7);
        for (int i = 0; i < 10; i++) begin
            a        = 8'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            chk("bp/ovalid", 16'({out_valid0, out_valid1}), 16'b11);
            chk("bp/ready",  16'({in_ready0, in_ready1}), 16'b00);
            chk("bp/d0",     16'(d0), 16'h53);
            chk("bp/d1",     16'(d1), 16'(ginv_t[8'hED]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pop_chk("bp");
        @(negedge clk);
        chk("bp/release", 16'({in_ready0, out_valid0}), 16'b10);
        @(negedge clk);
        chk("bp/no_extra", 16'({busy0, busy1}), 16'b00);

        // Reset during CALC aborts the pending result.
        a        = 8'h16;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rc/busy_pre", 16'(busy0), 16'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rc/ready", 16'({in_ready0, in_ready1}), 16'b11);
        chk("rc/d",     16'({d0, d1}), 16'h0000);
        chk("rc/busy",  16'({busy0, busy1}), 16'b00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rc/no_ovalid", 16'({out_valid0, out_valid1}), 16'b00);
        end

        // Reset during CALC, then accept on the first edge after release.
        a        = 8'h63;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_one(8'h7C, 8'h01, ginv_t[8'h7C], "rc_reaccept");
        run_one(8'h00, 8'h52, 8'h00, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
